// File: rtl/corelet_ctrl_pkg.sv
// rtl/corelet_ctrl_pkg.sv - shared encodings for the corelet controller
//
// Purpose: inst bit positions driven to the corelet, controller state
//          encodings and a helper that assembles the inst word.
// Ports:   none (package).

package corelet_ctrl_pkg;

   // Bit positions inside the 4-bit inst word {l0_rd, l0_wr, execute, load}
   localparam int INST_LOAD  = 0;
   localparam int INST_EXEC  = 1;
   localparam int INST_L0_WR = 2;
   localparam int INST_L0_RD = 3;
   localparam int INST_W     = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_W_XFER = 3'd1,
      ST_W_LOAD = 3'd2,
      ST_W_GAP  = 3'd3,
      ST_A_XFER = 3'd4,
      ST_EXEC   = 3'd5,
      ST_DRAIN  = 3'd6,
      ST_DONE   = 3'd7
   } ctrl_state_t;

   function automatic logic [INST_W-1:0] pack_inst(input logic l0_rd,
                                                   input logic l0_wr,
                                                   input logic execute,
                                                   input logic load);
      logic [INST_W-1:0] v;
      v             = '0;
      v[INST_L0_RD] = l0_rd;
      v[INST_L0_WR] = l0_wr;
      v[INST_EXEC]  = execute;
      v[INST_LOAD]  = load;
      return v;
   endfunction

endpackage

// File: rtl/corelet_ctrl_xmem_l0_feeder.sv
// rtl/corelet_ctrl_xmem_l0_feeder.sv - streams a block of xmem words into corelet L0
//
// Purpose: after a go pulse, reads count words from xmem starting at base and
//          writes each into L0 the cycle it returns. A word that returns while
//          L0 is full is parked in a one-entry skid and written first once L0
//          frees up. phase_done pulses the cycle after the last L0 write.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   go             1-cycle pulse: latch base/count and start the block
//   base, count    first xmem address and number of words
//   o_ready_l0     corelet L0 not-full
//   xmem_dout      xmem read data (one cycle after xmem_ren)
//   xmem_ren       xmem read enable
//   xmem_addr      xmem read address
//   l0_wr, l0_din  L0 write strobe and data
//   phase_done     1-cycle pulse when every word of the block is in L0

module xmem_l0_feeder #(
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          go,
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] count,
   input  logic          o_ready_l0,
   input  logic [DW-1:0] xmem_dout,
   output logic          xmem_ren,
   output logic [AW-1:0] xmem_addr,
   output logic          l0_wr,
   output logic [DW-1:0] l0_din,
   output logic          phase_done
);

   logic          active;
   logic          in_flight;
   logic          skid_valid;
   logic [DW-1:0] skid_data;
   logic [AW-1:0] issued;
   logic [AW-1:0] written;
   logic          wr_from_skid;
   logic          wr_from_fly;
   logic          last_write;

   // A read is only issued with the skid empty, and the skid only fills when
   // L0 is full (no read that cycle), so a returning word and a full skid
   // never coincide: one skid entry is enough.
   always_comb begin
      xmem_ren     = active && (issued != count) && o_ready_l0 && !skid_valid;
      wr_from_skid = skid_valid && o_ready_l0;
      wr_from_fly  = in_flight && o_ready_l0 && !skid_valid;
      l0_wr        = wr_from_skid || wr_from_fly;
      l0_din       = skid_valid ? skid_data : xmem_dout;
      last_write   = l0_wr && (written == count - AW'(1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active     <= 1'b0;
         in_flight  <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         issued     <= '0;
         written    <= '0;
         xmem_addr  <= '0;
         phase_done <= 1'b0;
      end else begin
         phase_done <= 1'b0;
         in_flight  <= xmem_ren;
         if (go) begin
            active     <= 1'b1;
            issued     <= '0;
            written    <= '0;
            xmem_addr  <= base;
            skid_valid <= 1'b0;
         end else if (active) begin
            if (xmem_ren) begin
               issued    <= issued + AW'(1);
               xmem_addr <= xmem_addr + AW'(1);
            end
            if (in_flight && !o_ready_l0) begin
               skid_valid <= 1'b1;
               skid_data  <= xmem_dout;
            end else if (wr_from_skid) begin
               skid_valid <= 1'b0;
            end
            if (l0_wr) begin
               written <= written + AW'(1);
            end
            if (last_write) begin
               active     <= 1'b0;
               phase_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - corelet instruction/memory initiator
//
// Purpose: for each of NUM_KIJ kernel positions, streams col weight words and
//          NUM_ACT activation words from xmem into L0, issues l0_rd/load and
//          l0_rd/execute sequences, and services psum SRAM reads/writes
//          requested by the corelet (rd_ofifo / wr_mem).
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start / busy / done      job handshake (done is a 1-cycle pulse)
//   xmem_ren/addr/dout       xmem read port (1-cycle read latency)
//   l0_din, inst             corelet D_xmem and {l0_rd, l0_wr, execute, load}
//   o_ready_l0               corelet L0 not-full
//   rd_ofifo, wr_mem         corelet OFIFO read strobe / SFU result valid
//   pmem_ren/raddr           psum SRAM read port
//   pmem_wen/waddr           psum SRAM write port
//   psum_first               high while kij==0 so the datapath zeroes old psums

module corelet_ctrl
   import corelet_ctrl_pkg::*;
#(
   parameter int bw       = 4,
   parameter int row      = 8,
   parameter int col      = 8,
   parameter int NUM_ACT  = 36,
   parameter int NUM_KIJ  = 9,
   parameter int WBASE    = 64,
   parameter int LOAD_GAP = 8,
   parameter int AW       = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              xmem_ren,
   output logic [AW-1:0]     xmem_addr,
   input  logic [bw*row-1:0] xmem_dout,
   output logic [bw*row-1:0] l0_din,
   output logic [3:0]        inst,
   input  logic              o_ready_l0,
   input  logic              rd_ofifo,
   input  logic              wr_mem,
   output logic              pmem_ren,
   output logic [AW-1:0]     pmem_raddr,
   output logic              pmem_wen,
   output logic [AW-1:0]     pmem_waddr,
   output logic              psum_first
);

   localparam int            DW       = bw * row;
   localparam int            KW       = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;
   localparam logic [AW-1:0] COL_N    = AW'(col);
   localparam logic [AW-1:0] ACT_N    = AW'(NUM_ACT);
   localparam logic [AW-1:0] GAP_N    = AW'(LOAD_GAP);
   localparam logic [AW-1:0] WBASE_A  = AW'(WBASE);
   localparam logic [KW-1:0] KIJ_LAST = KW'(NUM_KIJ - 1);

   ctrl_state_t   state;
   logic [KW-1:0] kij;
   logic [AW-1:0] cnt;
   logic [AW-1:0] rcnt;
   logic [AW-1:0] wcnt;
   logic          l0_rd_q;
   logic          load_q;
   logic          exec_q;
   logic          feed_go;
   logic [AW-1:0] feed_base;
   logic [AW-1:0] feed_count;
   logic          feed_l0_wr;
   logic          feed_done;
   logic [AW-1:0] next_wbase;

   xmem_l0_feeder #(
      .AW (AW),
      .DW (DW)
   ) u_feeder (
      .clk        (clk),
      .reset      (reset),
      .go         (feed_go),
      .base       (feed_base),
      .count      (feed_count),
      .o_ready_l0 (o_ready_l0),
      .xmem_dout  (xmem_dout),
      .xmem_ren   (xmem_ren),
      .xmem_addr  (xmem_addr),
      .l0_wr      (feed_l0_wr),
      .l0_din     (l0_din),
      .phase_done (feed_done)
   );

   // Weight block of the following kij
   assign next_wbase = WBASE_A + (AW'(kij) + AW'(1)) * COL_N;

   // Psum port follows the corelet strobes combinationally so the read data
   // lands one cycle later, aligned with the SFU result. Writes past NUM_ACT
   // are dropped and the counter holds.
   assign pmem_ren   = busy && rd_ofifo;
   assign pmem_raddr = rcnt;
   assign pmem_wen   = busy && wr_mem && (wcnt < ACT_N);
   assign pmem_waddr = wcnt;
   assign psum_first = busy && (kij == '0);

   assign inst = pack_inst(l0_rd_q, feed_l0_wr, exec_q, load_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         kij        <= '0;
         cnt        <= '0;
         rcnt       <= '0;
         wcnt       <= '0;
         l0_rd_q    <= 1'b0;
         load_q     <= 1'b0;
         exec_q     <= 1'b0;
         feed_go    <= 1'b0;
         feed_base  <= '0;
         feed_count <= '0;
      end else begin
         done    <= 1'b0;
         feed_go <= 1'b0;
         if (pmem_ren) begin
            rcnt <= rcnt + AW'(1);
         end
         if (pmem_wen) begin
            wcnt <= wcnt + AW'(1);
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy       <= 1'b1;
                  kij        <= '0;
                  rcnt       <= '0;
                  wcnt       <= '0;
                  feed_go    <= 1'b1;
                  feed_base  <= WBASE_A;
                  feed_count <= COL_N;
                  state      <= ST_W_XFER;
               end
            end

            ST_W_XFER: begin
               if (feed_done) begin
                  l0_rd_q <= 1'b1;
                  cnt     <= '0;
                  state   <= ST_W_LOAD;
               end
            end

            // l0_rd for col cycles; load trails it by one cycle to cover the
            // L0 read latency, so the state lasts col+1 cycles.
            ST_W_LOAD: begin
               load_q  <= l0_rd_q;
               l0_rd_q <= (cnt < COL_N - AW'(1));
               if (cnt == COL_N) begin
                  cnt   <= '0;
                  state <= ST_W_GAP;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end

            ST_W_GAP: begin
               if (cnt == GAP_N - AW'(1)) begin
                  cnt        <= '0;
                  feed_go    <= 1'b1;
                  feed_base  <= '0;
                  feed_count <= ACT_N;
                  state      <= ST_A_XFER;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end

            ST_A_XFER: begin
               if (feed_done) begin
                  l0_rd_q <= 1'b1;
                  cnt     <= '0;
                  state   <= ST_EXEC;
               end
            end

            ST_EXEC: begin
               exec_q  <= l0_rd_q;
               l0_rd_q <= (cnt < ACT_N - AW'(1));
               if (cnt == ACT_N) begin
                  cnt   <= '0;
                  state <= ST_DRAIN;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end

            ST_DRAIN: begin
               if (wcnt == ACT_N) begin
                  if (kij == KIJ_LAST) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     kij        <= kij + KW'(1);
                     rcnt       <= '0;
                     wcnt       <= '0;
                     feed_go    <= 1'b1;
                     feed_base  <= next_wbase;
                     feed_count <= COL_N;
                     state      <= ST_W_XFER;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb/tb_corelet_ctrl.sv - directed bench for corelet_ctrl

module tb_corelet_ctrl;

   localparam int BW       = 4;
   localparam int ROW      = 8;
   localparam int COL      = 8;
   localparam int NUM_ACT  = 36;
   localparam int NUM_KIJ  = 9;
   localparam int WBASE    = 64;
   localparam int LOAD_GAP = 8;
   localparam int AW       = 11;
   localparam int DW       = BW * ROW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic          xmem_ren;
   logic [AW-1:0] xmem_addr;
   logic [DW-1:0] xmem_dout;
   logic [DW-1:0] l0_din;
   logic [3:0]    inst;
   logic          o_ready_l0;
   logic          rd_ofifo;
   logic          wr_mem;
   logic          pmem_ren;
   logic [AW-1:0] pmem_raddr;
   logic          pmem_wen;
   logic [AW-1:0] pmem_waddr;
   logic          psum_first;

   corelet_ctrl #(
      .bw(BW), .row(ROW), .col(COL), .NUM_ACT(NUM_ACT), .NUM_KIJ(NUM_KIJ),
      .WBASE(WBASE), .LOAD_GAP(LOAD_GAP), .AW(AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .xmem_ren   (xmem_ren),
      .xmem_addr  (xmem_addr),
      .xmem_dout  (xmem_dout),
      .l0_din     (l0_din),
      .inst       (inst),
      .o_ready_l0 (o_ready_l0),
      .rd_ofifo   (rd_ofifo),
      .wr_mem     (wr_mem),
      .pmem_ren   (pmem_ren),
      .pmem_raddr (pmem_raddr),
      .pmem_wen   (pmem_wen),
      .pmem_waddr (pmem_waddr),
      .psum_first (psum_first)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] word_of(input int a);
      return DW'(32'hC0DE_0000 | a);
   endfunction

   // observation and corelet-model state
   int            q_x[$];
   logic [DW-1:0] q_l0[$];
   int  load_cnt, exec_cnt, done_cnt, busy_cnt, wr_cnt, rd_cnt, both_cnt;
   int  bad_w, bad_r, bad_pf, exp_r, exp_w, exec_in_kij, pend_rd, drop_left;
   bit  model_en, drop_armed;
   logic busy_at_done;

   task automatic clear_obs();
      q_x.delete();
      q_l0.delete();
      load_cnt = 0; exec_cnt = 0; done_cnt = 0; busy_cnt = 0;
      wr_cnt = 0; rd_cnt = 0; both_cnt = 0; bad_w = 0; bad_r = 0; bad_pf = 0;
      exp_r = 0; exp_w = 0; exec_in_kij = 0; pend_rd = 0; drop_left = 0;
      drop_armed = 1'b0; busy_at_done = 1'b1;
   endtask

   // One clock: entered at a negedge with inputs set; observes outputs,
   // crosses the posedge, then drives next-cycle xmem data and corelet strobes.
   task automatic cyc();
      bit            x_pend;
      logic [AW-1:0] x_addr;
      #1;
      x_pend = xmem_ren;
      x_addr = xmem_addr;
      if (xmem_ren) q_x.push_back(int'(xmem_addr));
      if (inst[2]) q_l0.push_back(l0_din);
      if (inst[0]) begin
         if (psum_first != (load_cnt < COL)) bad_pf++;
         load_cnt++;
      end
      if (!busy && psum_first) bad_pf++;
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         busy_at_done = busy;
      end
      if (pmem_ren) begin
         if (int'(pmem_raddr) != exp_r) bad_r++;
         exp_r++;
         rd_cnt++;
      end
      if (pmem_wen) begin
         if (int'(pmem_waddr) != exp_w) bad_w++;
         exp_w++;
         wr_cnt++;
      end
      if (pmem_ren && pmem_wen) both_cnt++;
      if (inst[1]) begin
         exec_cnt++;
         exec_in_kij++;
         if (exec_in_kij == NUM_ACT) begin
            exec_in_kij = 0;
            pend_rd     = NUM_ACT;
            exp_r       = 0;
            exp_w       = 0;
         end
      end
      if (drop_armed && xmem_ren && (int'(xmem_addr) == 17)) begin
         drop_armed = 1'b0;
         drop_left  = 3;
      end
      @(posedge clk);
      @(negedge clk);
      xmem_dout = x_pend ? word_of(int'(x_addr)) : DW'(32'hDEAD_BEEF);
      if (model_en) begin
         wr_mem   = rd_ofifo;
         rd_ofifo = (pend_rd > 0);
         if (pend_rd > 0) pend_rd--;
      end
      if (drop_left > 0) begin
         o_ready_l0 = 1'b0;
         drop_left--;
      end else begin
         o_ready_l0 = 1'b1;
      end
   endtask

   task automatic run_job(input bit drop, input int restart_at, input int reset_at_exec);
      clear_obs();
      model_en   = 1'b1;
      drop_armed = drop;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         if (done_cnt != 0) break;
         if (reset_at_exec > 0 && exec_cnt >= reset_at_exec) break;
         start = (c == restart_at);
         cyc();
      end
      start = 1'b0;
   endtask

   task automatic check_job(input string tag);
      int exp_x[$];
      int bad_x;
      int bad_l;
      bad_x = 0;
      bad_l = 0;
      for (int k = 0; k < NUM_KIJ; k++) begin
         for (int w = 0; w < COL; w++) exp_x.push_back(WBASE + k * COL + w);
         for (int a = 0; a < NUM_ACT; a++) exp_x.push_back(a);
      end
      for (int i = 0; i < q_x.size() && i < exp_x.size(); i++)
         if (q_x[i] != exp_x[i]) bad_x++;
      for (int i = 0; i < q_l0.size() && i < exp_x.size(); i++)
         if (q_l0[i] != word_of(exp_x[i])) bad_l++;
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_busy_at_done"}, busy_at_done, 0);
      check({tag, "_xmem_reads"}, q_x.size(), NUM_KIJ * (COL + NUM_ACT));
      check({tag, "_xmem_addr_order"}, bad_x, 0);
      check({tag, "_l0_writes"}, q_l0.size(), NUM_KIJ * (COL + NUM_ACT));
      check({tag, "_l0_data_order"}, bad_l, 0);
      check({tag, "_load_cycles"}, load_cnt, NUM_KIJ * COL);
      check({tag, "_exec_cycles"}, exec_cnt, NUM_KIJ * NUM_ACT);
      check({tag, "_pmem_writes"}, wr_cnt, NUM_KIJ * NUM_ACT);
      check({tag, "_pmem_waddr_seq"}, bad_w, 0);
      check({tag, "_pmem_reads"}, rd_cnt, NUM_KIJ * NUM_ACT);
      check({tag, "_pmem_raddr_seq"}, bad_r, 0);
      check({tag, "_rd_wr_same_cycle"}, both_cnt, NUM_KIJ * (NUM_ACT - 1));
      check({tag, "_psum_first"}, bad_pf, 0);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      o_ready_l0 = 1'b1;
      rd_ofifo   = 1'b0;
      wr_mem     = 1'b0;
      xmem_dout  = '0;
      model_en   = 1'b0;
      clear_obs();
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_inst", inst, 0);
      check("rst_xmem_ren", xmem_ren, 0);
      check("rst_xmem_addr", xmem_addr, 0);
      check("rst_pmem_ren", pmem_ren, 0);
      check("rst_pmem_wen", pmem_wen, 0);
      check("rst_pmem_raddr", pmem_raddr, 0);
      check("rst_pmem_waddr", pmem_waddr, 0);
      check("rst_psum_first", psum_first, 0);
      @(negedge clk);
      reset = 1'b0;

      // full job, L0 always ready, a stray start pulse while busy
      run_job(1'b0, 40, 0);
      repeat (6) cyc();
      check_job("job1");

      // idle: corelet strobes must not reach pmem
      model_en = 1'b0;
      clear_obs();
      rd_ofifo = 1'b1;
      wr_mem   = 1'b1;
      repeat (10) cyc();
      rd_ofifo = 1'b0;
      wr_mem   = 1'b0;
      check("idle_pmem_writes", wr_cnt, 0);
      check("idle_pmem_reads", rd_cnt, 0);
      check("idle_busy", busy_cnt, 0);

      // L0 back-pressure for 3 cycles with activation word 17 in flight
      run_job(1'b1, -1, 0);
      repeat (6) cyc();
      check("job2_drop_fired", drop_armed, 0);
      check_job("job2");

      // reset in the middle of kij 3 EXEC
      run_job(1'b0, -1, 3 * NUM_ACT + 10);
      check("rst_mid_in_exec", exec_cnt, 3 * NUM_ACT + 10);
      reset = 1'b1;
      cyc();
      reset    = 1'b0;
      model_en = 1'b0;
      rd_ofifo = 1'b1;
      wr_mem   = 1'b1;
      #1;
      check("rst_mid_inst", inst, 0);
      check("rst_mid_xmem_ren", xmem_ren, 0);
      check("rst_mid_pmem_ren", pmem_ren, 0);
      check("rst_mid_pmem_wen", pmem_wen, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_psum_first", psum_first, 0);
      @(negedge clk);
      rd_ofifo = 1'b0;
      wr_mem   = 1'b0;

      // restart after reset runs clean
      run_job(1'b0, -1, 0);
      repeat (6) cyc();
      check_job("job4");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
